// File: rtl/color_marker_classifier_pkg.sv
// Shared types and helpers for the colour-marker classifier: colour codes,
// coordinate widths, pipeline stage records and window field slicing.
package object_pkg;

   localparam int NUM_COLORS = 4;
   localparam int X_W        = 10;
   localparam int Y_W        = 9;

   localparam logic [1:0] COLOR_A = 2'd0;
   localparam logic [1:0] COLOR_B = 2'd1;
   localparam logic [1:0] COLOR_C = 2'd2;
   localparam logic [1:0] COLOR_D = 2'd3;

   // Stage-1 record: raw per-window matches plus the pixel's position.
   typedef struct packed {
      logic [NUM_COLORS-1:0] match;
      logic [X_W-1:0]        x;
      logic [Y_W-1:0]        y;
      logic                  vs;
   } s1_t;

   // Encoded candidate presented to the output/hit-cap stage.
   typedef struct packed {
      logic           hit;
      logic [1:0]     col;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           vs;
   } cand_t;

   function automatic logic [7:0] cr_min(input logic [31:0] win);
      return win[31:24];
   endfunction

   function automatic logic [7:0] cr_max(input logic [31:0] win);
      return win[23:16];
   endfunction

   function automatic logic [7:0] cb_min(input logic [31:0] win);
      return win[15:8];
   endfunction

   function automatic logic [7:0] cb_max(input logic [31:0] win);
      return win[7:0];
   endfunction

endpackage

// File: rtl/color_window_match.sv
// Inclusive Cr/Cb compare of one pixel against one packed colour window.
module color_window_match
   import object_pkg::*;
(
   input  logic [31:0] win,
   input  logic [7:0]  cr,
   input  logic [7:0]  cb,
   output logic        hit
);

   assign hit = (cr >= cr_min(win)) && (cr <= cr_max(win)) &&
                (cb >= cb_min(win)) && (cb <= cb_max(win));

endmodule

// File: rtl/color_marker_classifier.sv
// Classifies the YCrCb pixel stream against four colour windows and reports
// matching pixel coordinates. Optional run-length filter: define RUN_FILTER_EN.
module color_marker_classifier
   import object_pkg::*;
#(
   parameter logic [31:0] WIN0     = 32'h00000000,
   parameter logic [31:0] WIN1     = 32'h00000000,
   parameter logic [31:0] WIN2     = 32'h00000000,
   parameter logic [31:0] WIN3     = 32'h00000000,
   parameter logic [7:0]  Y_MIN    = 8'd32,
   parameter logic [7:0]  MAX_HITS = 8'd255,
   parameter int          RUN_LEN  = 3
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           pixel_valid,
   input  logic [7:0]     luma,
   input  logic [7:0]     cr,
   input  logic [7:0]     cb,
   input  logic           hsync,
   input  logic           vsync,
   output logic [1:0]     color,
   output logic [X_W-1:0] interesting_x,
   output logic [Y_W-1:0] interesting_y,
   output logic           interesting_flag,
   output logic           frame_flag
);

   localparam logic [NUM_COLORS-1:0][31:0] WINS = {WIN3, WIN2, WIN1, WIN0};

   logic [X_W-1:0]                x;
   logic [Y_W-1:0]                y;
   logic                          vs_d;
   logic                          synced;
   logic [NUM_COLORS-1:0]         win_hit;
   s1_t                           s1;
   logic                          enc_hit;
   logic [1:0]                    enc_col;
   cand_t                         fin;
   logic [NUM_COLORS-1:0][7:0]    hit_cnt;
   logic                          flag_ok;

   for (genvar k = 0; k < NUM_COLORS; k++) begin : g_win
      color_window_match u_match (
         .win (WINS[k]),
         .cr  (cr),
         .cb  (cb),
         .hit (win_hit[k])
      );
   end

   // hsync wins over pixel_valid so a pixel on the hsync cycle keeps its x.
   always_ff @(posedge clk) begin
      if (reset || vsync) begin
         x <= '0;
         y <= '0;
      end else if (hsync) begin
         x <= '0;
         if (y != '1) y <= y + 1'b1;
      end else if (pixel_valid && x != '1) begin
         x <= x + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_d   <= 1'b0;
         synced <= 1'b0;
      end else begin
         vs_d <= vsync;
         if (vs_d && !vsync) synced <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
      end else begin
         s1.match <= (pixel_valid && !vsync && luma >= Y_MIN) ? win_hit : '0;
         s1.x     <= x;
         s1.y     <= y;
         s1.vs    <= vsync;
      end
   end

   // Lowest window index wins on overlap.
   always_comb begin
      enc_hit = |s1.match;
      enc_col = COLOR_A;
      for (int k = NUM_COLORS - 1; k >= 0; k--)
         if (s1.match[k]) enc_col = 2'(k);
   end

`ifdef RUN_FILTER_EN
   localparam logic [2:0] RUN_THR = 3'(RUN_LEN);

   logic       s1_vld;
   logic       s1_hs;
   logic [2:0] run_cnt;
   logic [2:0] run_nx;
   logic [1:0] run_col;
   cand_t      s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_hs  <= 1'b0;
      end else begin
         s1_vld <= pixel_valid && !vsync;
         s1_hs  <= hsync;
      end
   end

   // Idle cycles leave the run alone; only valid pixels extend or break it.
   always_comb begin
      run_nx = run_cnt;
      if (s1_vld) begin
         if (!enc_hit)
            run_nx = '0;
         else if (run_cnt != '0 && enc_col == run_col)
            run_nx = (run_cnt == 3'd7) ? run_cnt : run_cnt + 3'd1;
         else
            run_nx = 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt <= '0;
         run_col <= '0;
         s2      <= '0;
      end else begin
         run_cnt <= (s1_hs || s1.vs) ? 3'd0 : run_nx;
         if (enc_hit) run_col <= enc_col;
         s2.hit  <= enc_hit && (run_nx >= RUN_THR);
         s2.col  <= enc_col;
         s2.x    <= s1.x;
         s2.y    <= s1.y;
         s2.vs   <= s1.vs;
      end
   end

   assign fin = s2;
`else
   always_comb begin
      fin.hit = enc_hit;
      fin.col = enc_col;
      fin.x   = s1.x;
      fin.y   = s1.y;
      fin.vs  = s1.vs;
   end
`endif

   assign flag_ok = fin.hit && synced && (hit_cnt[fin.col] < MAX_HITS);

   // Counters clear on the same edge frame_flag rises; no candidate can hit then.
   always_ff @(posedge clk) begin
      if (reset) begin
         color            <= '0;
         interesting_x    <= '0;
         interesting_y    <= '0;
         interesting_flag <= 1'b0;
         frame_flag       <= 1'b0;
         hit_cnt          <= '0;
      end else begin
         frame_flag       <= fin.vs;
         interesting_flag <= flag_ok;
         if (flag_ok) begin
            color         <= fin.col;
            interesting_x <= fin.x;
            interesting_y <= fin.y;
         end
         for (int k = 0; k < NUM_COLORS; k++) begin
            if (fin.vs && !frame_flag)
               hit_cnt[k] <= '0;
            else if (flag_ok && fin.col == 2'(k))
               hit_cnt[k] <= hit_cnt[k] + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_color_marker_classifier.sv
// Directed bench for color_marker_classifier: vector table plus hand-written
// frame, hit-cap, reset and run-filter sequences.
module tb_color_marker_classifier;
   import object_pkg::*;

`ifdef RUN_FILTER_EN
   localparam int LAT = 3;
   localparam bit RUN = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit RUN = 1'b0;
`endif

   localparam logic [31:0] W0 = {8'd150, 8'd200, 8'd80,  8'd120};
   localparam logic [31:0] W1 = {8'd140, 8'd170, 8'd90,  8'd110};
   localparam logic [31:0] W2 = {8'd20,  8'd40,  8'd200, 8'd230};
   localparam logic [31:0] W3 = {8'd60,  8'd70,  8'd30,  8'd40};

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           pixel_valid = 1'b0;
   logic           hsync = 1'b0;
   logic           vsync = 1'b0;
   logic [7:0]     luma = '0, cr = '0, cb = '0;
   logic [1:0]     color;
   logic [X_W-1:0] interesting_x;
   logic [Y_W-1:0] interesting_y;
   logic           interesting_flag;
   logic           frame_flag;

   color_marker_classifier #(
      .WIN0(W0), .WIN1(W1), .WIN2(W2), .WIN3(W3),
      .Y_MIN(8'd32), .MAX_HITS(8'd255), .RUN_LEN(3)
   ) dut (
      .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
      .luma(luma), .cr(cr), .cb(cb), .hsync(hsync), .vsync(vsync),
      .color(color), .interesting_x(interesting_x), .interesting_y(interesting_y),
      .interesting_flag(interesting_flag), .frame_flag(frame_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] col;
      logic [9:0] x;
      logic [8:0] y;
   } flag_t;

   flag_t fq[$];
   int    cyc_n = 0;
   int    n_tot = 0;
   int    n_bad = 0;
   int    tb_x = 0;
   int    tb_y = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk)
      if (interesting_flag === 1'b1)
         fq.push_back('{cyc_n, color, interesting_x, interesting_y});

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      pixel_valid = 1'b0;
      hsync = 1'b0;
      repeat (n) step();
   endtask

   task automatic drive(input logic pv, input logic hs, input logic [7:0] l, r, b);
      pixel_valid = pv;
      hsync = hs;
      luma = l;
      cr = r;
      cb = b;
      step();
      pixel_valid = 1'b0;
      hsync = 1'b0;
      if (hs) begin
         tb_x = 0;
         tb_y++;
      end else if (pv) begin
         tb_x++;
      end
   endtask

   // vsync pulse with five blanking lines and a matching pixel inside blanking.
   task automatic vs_pulse();
      idle(1);
      vsync = 1'b1;
      step();
      chk("ff_lag", frame_flag, 1'b0);
      repeat (LAT - 1) step();
      chk("ff_rise", frame_flag, 1'b1);
      drive(1'b1, 1'b0, 8'd90, 8'd160, 8'd100);
      repeat (5) drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      vsync = 1'b0;
      step();
      chk("ff_hold", frame_flag, 1'b1);
      repeat (LAT - 1) step();
      chk("ff_fall", frame_flag, 1'b0);
      tb_x = 0;
      tb_y = 0;
   endtask

`ifndef RUN_FILTER_EN
   typedef struct {
      logic       pv;
      logic [7:0] luma, cr, cb;
      logic       exp_flag;
      logic [1:0] exp_col;
   } vec_t;

   vec_t vt[13];
`endif

   initial begin
      int n0, dc, ex, ey, lc, lx, ly;
      flag_t f;

`ifndef RUN_FILTER_EN
      vt[0]  = '{1'b1, 8'd90,  8'd160, 8'd100, 1'b1, 2'd0};
      vt[1]  = '{1'b1, 8'd20,  8'd160, 8'd100, 1'b0, 2'd0};
      vt[2]  = '{1'b1, 8'd90,  8'd145, 8'd95,  1'b1, 2'd1};
      vt[3]  = '{1'b1, 8'd32,  8'd150, 8'd80,  1'b1, 2'd0};
      vt[4]  = '{1'b1, 8'd31,  8'd150, 8'd80,  1'b0, 2'd0};
      vt[5]  = '{1'b1, 8'd90,  8'd200, 8'd120, 1'b1, 2'd0};
      vt[6]  = '{1'b1, 8'd90,  8'd201, 8'd120, 1'b0, 2'd0};
      vt[7]  = '{1'b1, 8'd90,  8'd150, 8'd79,  1'b0, 2'd0};
      vt[8]  = '{1'b1, 8'd255, 8'd30,  8'd215, 1'b1, 2'd2};
      vt[9]  = '{1'b1, 8'd200, 8'd65,  8'd35,  1'b1, 2'd3};
      vt[10] = '{1'b1, 8'd90,  8'd170, 8'd110, 1'b1, 2'd0};
      vt[11] = '{1'b1, 8'd90,  8'd0,   8'd0,   1'b0, 2'd0};
      vt[12] = '{1'b0, 8'd90,  8'd160, 8'd100, 1'b0, 2'd0};
`endif

      // Reset state
      reset = 1'b1;
      repeat (3) step();
      chk("rst_flag", interesting_flag, 1'b0);
      chk("rst_color", color, 2'd0);
      chk("rst_x", interesting_x, 10'd0);
      chk("rst_y", interesting_y, 9'd0);
      chk("rst_frame", frame_flag, 1'b0);
      reset = 1'b0;
      step();

      vs_pulse();
      chk("blank_flags", fq.size(), 0);
      chk("blank_color", color, 2'd0);
      chk("blank_x", interesting_x, 10'd0);
      chk("blank_y", interesting_y, 9'd0);

`ifndef RUN_FILTER_EN
      // Frame 1: line 10, starting at column 37
      repeat (10) drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      repeat (37) drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      lc = 0; lx = 0; ly = 0;
      for (int i = 0; i < 13; i++) begin
         n0 = fq.size();
         dc = cyc_n;
         ex = tb_x;
         ey = tb_y;
         drive(vt[i].pv, 1'b0, vt[i].luma, vt[i].cr, vt[i].cb);
         idle(LAT + 1);
         chk($sformatf("vec%0d_nflag", i), fq.size() - n0, vt[i].exp_flag);
         if (vt[i].exp_flag) begin
            lc = vt[i].exp_col;
            lx = ex;
            ly = ey;
            if (fq.size() > n0) begin
               f = fq[n0];
               chk($sformatf("vec%0d_lat", i), f.cyc - dc, LAT);
            end
         end
         chk($sformatf("vec%0d_color", i), color, lc);
         chk($sformatf("vec%0d_x", i), interesting_x, lx);
         chk($sformatf("vec%0d_y", i), interesting_y, ly);
      end

      // Pixel on the hsync cycle keeps its column; next pixel starts the new line
      n0 = fq.size();
      ex = tb_x;
      ey = tb_y;
      drive(1'b1, 1'b1, 8'd90, 8'd30, 8'd215);
      drive(1'b1, 1'b0, 8'd90, 8'd65, 8'd35);
      idle(LAT + 1);
      chk("hs_pix_n", fq.size() - n0, 2);
      if (fq.size() >= n0 + 2) begin
         chk("hs_pix_x", fq[n0].x, ex);
         chk("hs_pix_y", fq[n0].y, ey);
         chk("hs_next_x", fq[n0+1].x, 0);
         chk("hs_next_y", fq[n0+1].y, ey + 1);
         chk("hs_next_col", fq[n0+1].col, 2'd3);
      end
`else
      // Run filter: five colour-3 pixels at columns 100..104
      drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      repeat (100) drive(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      n0 = fq.size();
      dc = cyc_n;
      repeat (5) drive(1'b1, 1'b0, 8'd90, 8'd65, 8'd35);
      idle(LAT + 2);
      chk("run_n", fq.size() - n0, 3);
      for (int j = 0; j < 3; j++) begin
         if (fq.size() > n0 + j) begin
            f = fq[n0+j];
            chk($sformatf("run%0d_x", j), f.x, 102 + j);
            chk($sformatf("run%0d_col", j), f.col, 2'd3);
            chk($sformatf("run%0d_lat", j), f.cyc - dc, LAT + 2 + j);
         end
      end
`endif

      // Hit cap: 300 colour-2 pixels in one frame
      vs_pulse();
      drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      n0 = fq.size();
      repeat (300) drive(1'b1, 1'b0, 8'd90, 8'd30, 8'd215);
      idle(LAT + 2);
      chk("cap_n", fq.size() - n0, 255);
      if (fq.size() > n0) chk("cap_last_x", fq[$].x, RUN ? 256 : 254);

      // Next frame: colour 2 flags again
      vs_pulse();
      drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      n0 = fq.size();
      repeat (3) drive(1'b1, 1'b0, 8'd90, 8'd30, 8'd215);
      idle(LAT + 2);
      chk("cap_clr_n", fq.size() - n0, RUN ? 1 : 3);
      if (fq.size() > n0) begin
         chk("cap_clr_x", fq[n0].x, RUN ? 2 : 0);
         chk("cap_clr_col", fq[n0].col, 2'd2);
      end

      // Reset with a matching pixel sitting in stage 1
      n0 = fq.size();
      drive(1'b1, 1'b0, 8'd90, 8'd160, 8'd100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_flag", interesting_flag, 1'b0);
      chk("mrst_x", interesting_x, 10'd0);
      chk("mrst_color", color, 2'd0);
      idle(LAT + 1);
      repeat (5) drive(1'b1, 1'b0, 8'd90, 8'd160, 8'd100);
      idle(LAT + 2);
      chk("mrst_unsynced_n", fq.size() - n0, 0);

      vs_pulse();
      drive(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
      n0 = fq.size();
      repeat (3) drive(1'b1, 1'b0, 8'd90, 8'd160, 8'd100);
      idle(LAT + 2);
      chk("mrst_resync_n", fq.size() - n0, RUN ? 1 : 3);
      if (fq.size() > n0) chk("mrst_resync_y", fq[n0].y, 1);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/color_marker_classifier.md
Name: color_marker_classifier

Overview:
- Upstream stage of object_recognition. Takes the YCrCb pixel stream from the video decoder, keeps per-pixel x/y position counters, and classifies each pixel against four Cr/Cb colour windows (corner markers A–D).
- For every matching pixel it emits the colour code plus coordinates on the color / interesting_x / interesting_y / interesting_flag interface.
- Produces frame_flag, aligned with the pixel pipeline.

Parameters:
- WIN0, 32'h00000000, colour 0 window packed {cr_min, cr_max, cb_min, cb_max}, 8 bits each, inclusive bounds
- WIN1, 32'h00000000, colour 1 window, same packing
- WIN2, 32'h00000000, colour 2 window, same packing
- WIN3, 32'h00000000, colour 3 window, same packing
- Y_MIN, 8'd32, minimum luma for any match (rejects dark pixels)
- MAX_HITS, 8'd255, max flagged pixels per colour per frame (downstream count is 8 bits)
- RUN_LEN, 3, consecutive same-colour pixels required (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_valid  in  1  qualifies luma/cr/cb this cycle
- luma  in  8  Y component
- cr  in  8  Cr component
- cb  in  8  Cb component
- hsync  in  1  single-cycle pulse, end of active line
- vsync  in  1  level, high during vertical blanking
- color  out  2  matched colour index
- interesting_x  out  10  pixel column
- interesting_y  out  9  pixel row
- interesting_flag  out  1  single-cycle strobe; color/x/y valid
- frame_flag  out  1  vsync delayed to match pipeline latency

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - all outputs 0
  - x and y counters 0
  - per-colour hit counters 0
  - pipeline valid bits 0
  - synced bit 0
- Position counters:
  - x increments on each pixel_valid while vsync is low, saturating at 1023.
  - hsync sets x to 0 and increments y, saturating at 511.
  - vsync high holds x = 0 and y = 0.
  - hsync and pixel_valid in the same cycle: the pixel uses the current x, then x clears.
- Synced bit:
  - Set on the first vsync falling edge after reset.
  - interesting_flag is forced to 0 while synced = 0, so a mid-frame reset never produces flags with bogus coordinates.
- Pipeline, latency 2 cycles from pixel_valid to interesting_flag:
  - S1 registers the four window-compare results, the luma >= Y_MIN result, and x/y.
  - S2 priority-encodes the matches (lowest index wins on overlap), applies the hit cap, and drives the outputs.
- Qualification:
  - Pixels with pixel_valid = 0, vsync = 1, or luma < Y_MIN never match.
  - A matched pixel of colour k is flagged only if hit_cnt[k] < MAX_HITS; hit_cnt[k] then increments.
  - At MAX_HITS, further colour-k pixels are silently dropped for the rest of the frame.
- frame_flag:
  - Equals vsync delayed 2 cycles, so every flag for a frame precedes the frame_flag rise.
  - Hit counters clear on the frame_flag rising edge.
- Output persistence: color/x/y hold their last flagged values when interesting_flag = 0.
- Reset mid-operation: the pipeline is flushed in the same cycle and no stale flag appears.

Optional Feature:
- Macro: RUN_FILTER_EN.
- Defined:
  - A run counter, 3 bits wide and saturating, tracks consecutive valid pixels of the same colour on one line.
  - It resets on hsync, vsync, a non-matching pixel, or a colour change.
  - A pixel is flagged only when its run count reaches at least RUN_LEN; the flag carries that pixel's coordinates.
  - Adds one pipeline cycle: latency becomes 3, and frame_flag delay becomes 3.
- Undefined: every qualifying matched pixel is flagged, latency 2.

Decomposition:
- Package object_pkg:
  - colour code constants COLOR_A..COLOR_D = 0..3
  - X_W = 10, Y_W = 9
  - window field slicing functions (cr_min, cr_max, cb_min, cb_max)
- Sub-module color_window_match: purely combinational inclusive compare of cr/cb against one packed window. Instantiated four times.

Test Plan:
- Reset, then a vsync pulse, then 5 blanking lines → all outputs 0; no interesting_flag.
- Run 1: WIN0 = {8'd150, 8'd200, 8'd80, 8'd120}. After the vsync fall, drive a pixel at line 10, col 37 with cr = 160, cb = 100, luma = 90 → 2 cycles later interesting_flag = 1, color = 0, x = 37, y = 10.
- Run 2, same WIN0: drive the same pixel with luma = 20 → no flag.
- WIN1 overlapping WIN0, pixel inside both → color = 0.
- Hit cap: 300 colour-2 pixels in one frame → exactly 255 flags. Next frame, first colour-2 pixel → flagged again.
- Reset asserted mid-line with a matching pixel in S1 → no flag. No flags until the next vsync falling edge.
- RUN_FILTER_EN, RUN_LEN = 3: 5 consecutive colour-3 pixels at cols 100–104 → flags at cols 102, 103, 104 only; latency 3.
